regfile_scoreboard: RTL and testbench

//   Parametrised decode-stage register file with multiple read ports, optional

---
 rtl/regfile_scoreboard.sv | 85 ++++++++
 tb/tb_regfile_scoreboard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Decode register file: combinational multi-port reads with optional writeback bypass,
// plus per-register in-flight counters driving operand pending, decode stall and issue ready.
module regfile_scoreboard #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int MAX_INFLIGHT = 3,
  parameter int BYPASS       = 1,
  localparam int AW          = $clog2(NUM_REGS),
  localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NUM_RD_PORTS*AW-1:0]   REG_R_Addr,
  input  logic [NUM_RD_PORTS-1:0]      REG_R_Used,
  output logic [NUM_RD_PORTS*XLEN-1:0] REG_R_Data,
  output logic [NUM_RD_PORTS-1:0]      REG_R_Pending,
  output logic                         Stall_D,
  input  logic                         Issue_En,
  input  logic [AW-1:0]                Issue_Addr,
  output logic                         Issue_Ready,
  input  logic                         REG_W_En,
  input  logic [AW-1:0]                REG_W_Addr,
  input  logic [XLEN-1:0]              REG_W_Data,
  input  logic                         Flush,
  output logic                         Err_Underflow
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [CW-1:0]   cnt  [NUM_REGS];

  logic wb_vld;
  logic iss_vld;
  logic same_reg;

  // A writeback caught by an asserted reset must not leak through the bypass path.
  assign wb_vld      = REG_W_En && RST_N && (REG_W_Addr != '0);
  assign iss_vld     = Issue_En && (Issue_Addr != '0);
  assign same_reg    = iss_vld && wb_vld && (Issue_Addr == REG_W_Addr);
  assign Issue_Ready = (Issue_Addr == '0) || (cnt[Issue_Addr] != CNT_MAX);

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;

    assign ra  = REG_R_Addr[p*AW +: AW];
    assign hit = (BYPASS != 0) && wb_vld && (REG_W_Addr == ra);

    assign REG_R_Data[p*XLEN +: XLEN] = (ra == '0) ? '0 :
                                        hit        ? REG_W_Data : regs[ra];
    assign REG_R_Pending[p] = (ra != '0) && (cnt[ra] != '0) &&
                              !(hit && (cnt[ra] == CNT_ONE));
  end

  assign Stall_D = |(REG_R_Pending & REG_R_Used);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      Err_Underflow <= 1'b0;
    end else begin
      Err_Underflow <= wb_vld && !Flush && !same_reg && (cnt[REG_W_Addr] == '0);
      if (wb_vld) begin
        regs[REG_W_Addr] <= REG_W_Data;
      end
      // Matching issue and writeback on one register cancel each other out.
      for (int r = 1; r < NUM_REGS; r++) begin
        if (Flush) begin
          cnt[r] <= '0;
        end else if (iss_vld && (Issue_Addr == AW'(r)) && !same_reg && Issue_Ready) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (wb_vld && (REG_W_Addr == AW'(r)) && !same_reg && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: BYPASS=1 and BYPASS=0 instances share stimulus and are
// scored against a queue of expected outputs produced by an array-based reference model.
module tb_regfile_scoreboard;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  pend;
    logic        stall;
    logic        ready;
    logic        err;
  } exp_t;

  typedef struct packed {
    exp_t b1;
    exp_t b0;
    logic chk_err;
  } sb_item_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [9:0]  r_addr;
  logic [1:0]  r_used;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        flush;

  logic [63:0] data1, data0;
  logic [1:0]  pend1, pend0;
  logic        stall1, stall0, ready1, ready0, err1, err0;

  always #5 CLK = ~CLK;

  regfile_scoreboard #(.BYPASS(1)) dut_b1 (
    .CLK(CLK), .RST_N(RST_N), .REG_R_Addr(r_addr), .REG_R_Used(r_used),
    .REG_R_Data(data1), .REG_R_Pending(pend1), .Stall_D(stall1),
    .Issue_En(issue_en), .Issue_Addr(issue_addr), .Issue_Ready(ready1),
    .REG_W_En(w_en), .REG_W_Addr(w_addr), .REG_W_Data(w_data),
    .Flush(flush), .Err_Underflow(err1)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_b0 (
    .CLK(CLK), .RST_N(RST_N), .REG_R_Addr(r_addr), .REG_R_Used(r_used),
    .REG_R_Data(data0), .REG_R_Pending(pend0), .Stall_D(stall0),
    .Issue_En(issue_en), .Issue_Addr(issue_addr), .Issue_Ready(ready0),
    .REG_W_En(w_en), .REG_W_Addr(w_addr), .REG_W_Data(w_data),
    .Flush(flush), .Err_Underflow(err0)
  );

  // Reference model: architectural contents and outstanding-write counts.
  logic [31:0] mem [32];
  int          cnt [32];
  bit          err_next;
  bit          prev_flush;

  sb_item_t sb_q[$];
  int       checks = 0;
  int       errors = 0;

  function automatic exp_t predict(bit byp);
    exp_t e;
    e = '0;
    for (int p = 0; p < 2; p++) begin
      int a;
      bit hit;
      a   = int'(r_addr[p*5 +: 5]);
      hit = byp && RST_N && w_en && (int'(w_addr) == a) && (a != 0);
      if (RST_N && a != 0) begin
        e.data[p*32 +: 32] = hit ? w_data : mem[a];
        e.pend[p]          = (cnt[a] != 0) && !(hit && cnt[a] == 1);
      end
    end
    e.stall = |(e.pend & r_used);
    e.ready = (issue_addr == 5'd0) || (cnt[issue_addr] < 3);
    e.err   = RST_N && err_next;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] used, input bit ie, input logic [4:0] ia,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit fl);
    sb_item_t it;
    @(posedge CLK);
    #1;
    RST_N = rst; r_addr = {a1, a0}; r_used = used;
    issue_en = ie; issue_addr = ia;
    w_en = we; w_addr = wa; w_data = wd; flush = fl;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = '0;
        cnt[i] = 0;
      end
      err_next = 1'b0;
    end
    it.b1      = predict(1'b1);
    it.b0      = predict(1'b0);
    it.chk_err = !prev_flush;
    sb_q.push_back(it);
    if (rst) begin
      bit rdy, ih, wh, same;
      rdy  = (ia == 5'd0) || (cnt[ia] < 3);
      ih   = ie && (ia != 5'd0);
      wh   = we && (wa != 5'd0);
      same = ih && wh && (ia == wa);
      err_next = !fl && wh && !same && (cnt[wa] == 0);
      if (wh) mem[wa] = wd;
      if (fl) begin
        for (int i = 0; i < 32; i++) cnt[i] = 0;
      end else begin
        if (ih && !same && rdy) cnt[ia] = cnt[ia] + 1;
        if (wh && !same && cnt[wa] > 0) cnt[wa] = cnt[wa] - 1;
      end
      prev_flush = fl;
    end else begin
      prev_flush = 1'b0;
    end
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
    cycle(1'b1, a0, a1, used, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  always @(negedge CLK) begin
    if (sb_q.size() != 0) begin
      sb_item_t it;
      it = sb_q.pop_front();
      chk("data_byp1",  data1,         it.b1.data);
      chk("pend_byp1",  64'(pend1),    64'(it.b1.pend));
      chk("stall_byp1", 64'(stall1),   64'(it.b1.stall));
      chk("ready_byp1", 64'(ready1),   64'(it.b1.ready));
      chk("data_byp0",  data0,         it.b0.data);
      chk("pend_byp0",  64'(pend0),    64'(it.b0.pend));
      chk("stall_byp0", 64'(stall0),   64'(it.b0.stall));
      chk("ready_byp0", 64'(ready0),   64'(it.b0.ready));
      if (it.chk_err) begin
        chk("err_byp1", 64'(err1), 64'(it.b1.err));
        chk("err_byp0", 64'(err0), 64'(it.b0.err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; r_addr = '0; r_used = '0; issue_en = 1'b0; issue_addr = '0;
    w_en = 1'b0; w_addr = '0; w_data = '0; flush = 1'b0;
    prev_flush = 1'b0;
    err_next   = 1'b0;

    // Reset with pending state and an in-flight writeback
    cycle(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, 5'd5, 5'd0, 2'b01, 1'b1, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    cycle(1'b1, 5'd5, 5'd5, 2'b11, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b0, 5'd5, 5'd5, 2'b11, 1'b1, 5'd5, 1'b1, 5'd5, 32'h11111111, 1'b0);
    idle(5'd5, 5'd5, 2'b11);
    idle(5'd5, 5'd0, 2'b01);

    // Bypass versus old contents
    cycle(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd7, 32'h0000AAAA, 1'b0);
    cycle(1'b1, 5'd7, 5'd7, 2'b00, 1'b0, 5'd0, 1'b1, 5'd7, 32'h00001234, 1'b0);
    idle(5'd7, 5'd0, 2'b00);

    // Scoreboard stall and bypassed retirement
    cycle(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(5'd3, 5'd0, 2'b01);
    cycle(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 1'b1, 5'd3, 32'h00000055, 1'b0);
    idle(5'd3, 5'd3, 2'b11);

    // Saturation, refused issue, simultaneous issue and writeback
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 5'd9, 5'd0, 2'b01, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, 5'd9, 5'd0, 2'b01, 1'b1, 5'd9, 1'b1, 5'd9, 32'h00000099, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 5'd9, 5'd9, 2'b11, 1'b0, 5'd9, 1'b1, 5'd9, 32'(i), 1'b0);
    idle(5'd9, 5'd0, 2'b01);

    // Flush drops same-cycle issue, keeps same-cycle data write
    cycle(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, 5'd4, 5'd0, 2'b01, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, 5'd4, 5'd6, 2'b11, 1'b1, 5'd8, 1'b1, 5'd4, 32'h00000077, 1'b1);
    idle(5'd8, 5'd4, 2'b11);
    idle(5'd6, 5'd0, 2'b01);

    // Underflow pulse and register zero
    cycle(1'b1, 5'd2, 5'd0, 2'b01, 1'b0, 5'd0, 1'b1, 5'd2, 32'h00000022, 1'b0);
    idle(5'd2, 5'd0, 2'b01);
    idle(5'd2, 5'd0, 2'b01);
    cycle(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    cycle(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(5'd0, 5'd0, 2'b11);

    // Randomised traffic concentrated on a few registers
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 199) != 0), rnd_addr(), rnd_addr(), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 40), rnd_addr(),
            ($urandom_range(0, 99) < 45), rnd_addr(), $urandom,
            ($urandom_range(0, 99) < 3));
    end

    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
